mfi_check_sequencer: RTL and testbench

//  Sequences a formal/sim run for the MFI checkers. Holds the core and checkers in reset,

---
 rtl/mfi_check_sequencer_if.sv | 26 ++
 rtl/mfi_check_sequencer.sv | 114 +++++++++++
 tb/tb_mfi_check_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mfi_check_sequencer_if.sv
// MFI retirement inputs and sequencer status outputs shared between the core-side
// harness (master) and the check sequencer (slave).
interface mfi_check_sequencer_if #(
  parameter int unsigned ORDER_W = 64,
  parameter int unsigned CNT_W   = 16
);
  logic               mfi_valid;
  logic [ORDER_W-1:0] mfi_order;
  logic               core_reset;
  logic               check;
  logic               done;
  logic               timeout;
  logic               order_error;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   retire_cnt;

  modport master (
    output mfi_valid, mfi_order,
    input  core_reset, check, done, timeout, order_error, cycle_cnt, retire_cnt
  );

  modport slave (
    input  mfi_valid, mfi_order,
    output core_reset, check, done, timeout, order_error, cycle_cnt, retire_cnt
  );
endinterface

// File: rtl/mfi_check_sequencer.sv
// Run sequencer for the MFI checkers: holds the core in reset, counts RUN cycles and
// retirements, fires a one-cycle check strobe, then parks in DONE. Flags order gaps.
module mfi_check_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CHECK_CYCLE  = 20,
  parameter int unsigned MIN_RETIRE   = 1,
  parameter int unsigned ORDER_W      = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  mfi_check_sequencer_if.slave mfi
);

  typedef enum logic [1:0] {S_RST, S_RUN, S_CHECK, S_DONE} state_e;

  localparam int unsigned      RST_N    = (RESET_CYCLES == 0) ? 1 : RESET_CYCLES;
  localparam logic [31:0]      RST_LAST = 32'(RST_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHECK_CYCLE - 1);
  localparam logic [CNT_W:0]   MIN_RET  = (CNT_W + 1)'(MIN_RETIRE);

  state_e             state_q, state_d;
  logic [31:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [ORDER_W-1:0] last_order_q, last_order_d;
  logic               have_order_q, have_order_d;
  logic               order_err_q, order_err_d;
  logic               timeout_q, timeout_d;
  logic               core_reset_q, core_reset_d;
  logic               check_q, check_d;
  logic               done_q, done_d;
  logic               counting;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    last_order_d = last_order_q;
    have_order_d = have_order_q;
    order_err_d  = order_err_q;
    timeout_d    = timeout_q;
    counting     = (state_q == S_RUN) || (state_q == S_CHECK);

    if (counting && mfi.mfi_valid) begin
      if (retire_cnt_q != CNT_MAX) retire_cnt_d = retire_cnt_q + 1'b1;
      if (have_order_q && (mfi.mfi_order != last_order_q + 1'b1)) order_err_d = 1'b1;
      last_order_d = mfi.mfi_order;
      have_order_d = 1'b1;
    end

    case (state_q)
      S_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        else rst_cnt_d = rst_cnt_q + 32'd1;
      end
      S_RUN: begin
        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + 1'b1;
        // retire_cnt_d already includes this cycle's retirement
        if ((cycle_cnt_q >= CHK_LAST) && ({1'b0, retire_cnt_d} >= MIN_RET)) begin
          state_d = S_CHECK;
        end else if (cycle_cnt_q == CNT_MAX) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_CHECK: state_d = S_DONE;
      default: state_d = S_DONE;
    endcase

    core_reset_d = (state_d == S_RST);
    check_d      = (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_RST;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      last_order_q <= '0;
      have_order_q <= 1'b0;
      order_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      check_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      last_order_q <= last_order_d;
      have_order_q <= have_order_d;
      order_err_q  <= order_err_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
      check_q      <= check_d;
      done_q       <= done_d;
    end
  end

  assign mfi.core_reset  = core_reset_q;
  assign mfi.check       = check_q;
  assign mfi.done        = done_q;
  assign mfi.timeout     = timeout_q;
  assign mfi.order_error = order_err_q;
  assign mfi.cycle_cnt   = cycle_cnt_q;
  assign mfi.retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_mfi_check_sequencer.sv
// Randomized bench for mfi_check_sequencer: three configurations run side by side and are
// compared every cycle against a history-based model of the sequencing rules.
module tb_mfi_check_sequencer;

  typedef struct packed {
    logic        core_reset;
    logic        check;
    logic        done;
    logic        timeout;
    logic        order_error;
    logic [15:0] cycle_cnt;
    logic [15:0] retire_cnt;
  } exp_t;

  // Effective reset length (RESET_CYCLES=0 behaves as 1), check cycle, min retire, widths
  localparam int unsigned P_R  [3] = '{2, 1, 3};
  localparam int unsigned P_CC [3] = '{5, 5, 1};
  localparam int unsigned P_MR [3] = '{1, 2, 0};
  localparam int unsigned P_CW [3] = '{16, 4, 4};
  localparam int unsigned P_OW [3] = '{64, 4, 8};
  localparam int unsigned HIST     = 128;

  logic        clock = 1'b0;
  logic        rst [3];
  logic        v   [3];
  logic [63:0] o   [3];
  exp_t        got [3];

  bit          hv [3][HIST];
  logic [63:0] ho [3][HIST];
  int unsigned t  [3];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  mfi_check_sequencer_if #(.ORDER_W(64), .CNT_W(16)) if_a ();
  mfi_check_sequencer_if #(.ORDER_W(4),  .CNT_W(4))  if_b ();
  mfi_check_sequencer_if #(.ORDER_W(8),  .CNT_W(4))  if_c ();

  mfi_check_sequencer #(.RESET_CYCLES(2), .CHECK_CYCLE(5), .MIN_RETIRE(1),
                        .ORDER_W(64), .CNT_W(16))
    dut_a (.clock(clock), .reset(rst[0]), .mfi(if_a.slave));
  mfi_check_sequencer #(.RESET_CYCLES(0), .CHECK_CYCLE(5), .MIN_RETIRE(2),
                        .ORDER_W(4), .CNT_W(4))
    dut_b (.clock(clock), .reset(rst[1]), .mfi(if_b.slave));
  mfi_check_sequencer #(.RESET_CYCLES(3), .CHECK_CYCLE(1), .MIN_RETIRE(0),
                        .ORDER_W(8), .CNT_W(4))
    dut_c (.clock(clock), .reset(rst[2]), .mfi(if_c.slave));

  assign if_a.mfi_valid = v[0];
  assign if_a.mfi_order = o[0];
  assign if_b.mfi_valid = v[1];
  assign if_b.mfi_order = o[1][3:0];
  assign if_c.mfi_valid = v[2];
  assign if_c.mfi_order = o[2][7:0];

  assign got[0] = {if_a.core_reset, if_a.check, if_a.done, if_a.timeout, if_a.order_error,
                   if_a.cycle_cnt, if_a.retire_cnt};
  assign got[1] = {if_b.core_reset, if_b.check, if_b.done, if_b.timeout, if_b.order_error,
                   12'd0, if_b.cycle_cnt, 12'd0, if_b.retire_cnt};
  assign got[2] = {if_c.core_reset, if_c.check, if_c.done, if_c.timeout, if_c.order_error,
                   12'd0, if_c.cycle_cnt, 12'd0, if_c.retire_cnt};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] omask(input int unsigned ow);
    return (ow >= 64) ? '1 : ((64'd1 << ow) - 64'd1);
  endfunction

  function automatic int unsigned sat(input int unsigned x, input int unsigned mx);
    return (x > mx) ? mx : x;
  endfunction

  // Expected outputs t cycles after reset, derived from the recorded input history.
  function automatic exp_t model(input int i, input int unsigned tt);
    exp_t        e;
    int unsigned r, mx, cnt, kend, win, cyc, ret;
    bit          found, is_chk, have, err;
    logic [63:0] prev, m;
    e = '0;
    r = P_R[i];
    mx = (32'd1 << P_CW[i]) - 32'd1;
    m = omask(P_OW[i]);
    if (tt < r) begin
      e.core_reset = 1'b1;
      return e;
    end
    found = 0; is_chk = 0; cnt = 0; kend = 0;
    for (int unsigned k = 0; r + k < tt; k++) begin
      cnt += hv[i][r+k] ? 1 : 0;
      if (k + 1 >= P_CC[i] && sat(cnt, mx) >= P_MR[i]) begin
        found = 1; is_chk = 1; kend = k; break;
      end
      if (k == mx) begin
        found = 1; kend = k; break;
      end
    end
    if (!found) begin
      win = tt - r;
      cyc = tt - r;
    end else begin
      cyc = sat(kend + 1, mx);
      if (is_chk && tt == r + kend + 1) begin
        e.check = 1'b1;
        win = kend + 1;
      end else begin
        e.done = 1'b1;
        e.timeout = !is_chk;
        win = kend + 1 + (is_chk ? 1 : 0);
      end
    end
    ret = 0; have = 0; err = 0; prev = '0;
    for (int unsigned j = 0; j < win; j++) begin
      if (hv[i][r+j]) begin
        ret++;
        if (have && ho[i][r+j] != ((prev + 64'd1) & m)) err = 1;
        prev = ho[i][r+j];
        have = 1;
      end
    end
    e.cycle_cnt   = 16'(cyc);
    e.retire_cnt  = 16'(sat(ret, mx));
    e.order_error = err;
    return e;
  endfunction

  initial begin
    int unsigned vp [3];
    int unsigned dl [3];
    int unsigned skp[3];
    int unsigned mra[3];
    logic [63:0] nxt[3];
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; v[i] = 1'b0; o[i] = '0; t[i] = 0;
    end
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 3; i++) begin
        vp[i]  = 100; dl[i] = 0; skp[i] = 0; mra[i] = 999; nxt[i] = '0;
        case (ep)
          0: ;
          1: dl[i] = 12;
          2: vp[i] = 0;
          3: mra[i] = 7;
          4: begin nxt[i] = 64'hFFFF_FFFF_FFFF_FFFE; skp[i] = 0; end
          5: begin dl[i] = 2; skp[i] = 40; end
          default: begin
            case ($urandom_range(0, 3))
              0: vp[i] = 0;
              1: vp[i] = 20;
              2: vp[i] = 60;
              default: vp[i] = 100;
            endcase
            dl[i]  = $urandom_range(0, 15);
            skp[i] = ($urandom_range(0, 3) == 0) ? 10 : 0;
            mra[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 999;
            nxt[i] = {$urandom, $urandom};
          end
        endcase
      end
      for (int c = 0; c < 44; c++) begin
        for (int i = 0; i < 3; i++) begin
          rst[i] = (c == 0) || (c == int'(mra[i]));
          v[i]   = !rst[i] && (c >= int'(dl[i]) + 1) && ($urandom_range(0, 99) < vp[i]);
          if (v[i]) begin
            o[i]   = nxt[i];
            nxt[i] = nxt[i] + (($urandom_range(0, 99) < skp[i]) ? 64'd2 : 64'd1);
          end else begin
            o[i] = {$urandom, $urandom};
          end
        end
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
          if (rst[i]) begin
            t[i] = 0;
          end else if (t[i] < HIST) begin
            hv[i][t[i]] = v[i];
            ho[i][t[i]] = o[i] & omask(P_OW[i]);
            t[i]++;
          end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
          e = model(i, t[i]);
          check_eq($sformatf("core_reset[%0d]", i), 64'(got[i].core_reset), 64'(e.core_reset));
          check_eq($sformatf("check[%0d]", i), 64'(got[i].check), 64'(e.check));
          check_eq($sformatf("done[%0d]", i), 64'(got[i].done), 64'(e.done));
          check_eq($sformatf("timeout[%0d]", i), 64'(got[i].timeout), 64'(e.timeout));
          check_eq($sformatf("order_error[%0d]", i), 64'(got[i].order_error),
                   64'(e.order_error));
          check_eq($sformatf("cycle_cnt[%0d]", i), 64'(got[i].cycle_cnt), 64'(e.cycle_cnt));
          check_eq($sformatf("retire_cnt[%0d]", i), 64'(got[i].retire_cnt),
                   64'(e.retire_cnt));
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
